// File: rtl/data_memory_be.sv
// data_memory_be: byte-addressable 2**ADDR_WIDTH x 32 data memory for the MIPS MEM stage.
// Latency: loads return 1 cycle after the request (registered rdata/rdata_valid); stores commit on the request edge.
// Backpressure: none per request; busy is high during the post-reset clear sweep and requests are dropped while it is set.
//
// Ports: clk/reset (sync, active-high); pc (trace only); req_valid/req_we/req_size/req_unsigned/addr/wdata
//        request; busy, rdata_valid, rdata, misalign responses.
// Optional: define DM_TRACE_EN to print one line per committed store.
module data_memory_be #(
    parameter int ADDR_WIDTH     = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        misalign
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic [ADDR_WIDTH-1:0]   w_clr_cnt_nxt;
    logic                    w_busy;

    logic [31:0]             r_mem [DEPTH];
    logic                    r_rdata_valid;
    logic [31:0]             r_rdata;
    logic                    r_misalign;

    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [1:0]              w_lane;
    logic                    w_misal;
    logic                    w_accept;
    logic                    w_commit_st;
    logic                    w_load;
    logic [31:0]             w_word;
    logic [31:0]             w_merged;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_ext;

    // Upper address bits wrap; pc only feeds the optional trace.
    logic                    w_unused;
    assign w_unused = ^{pc, addr[31:ADDR_WIDTH+2]};

    // ------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET) r_state <= ST_CLEAR;
            else                r_state <= ST_READY;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_busy        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy        = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == {ADDR_WIDTH{1'b1}}) w_state_nxt = ST_READY;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign busy = w_busy;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_idx  = addr[ADDR_WIDTH+1:2];
    assign w_lane = addr[1:0];

    always_comb begin
        w_misal = 1'b0;
        case (req_size)
            2'b00:   w_misal = 1'b0;
            2'b01:   w_misal = addr[0];
            default: w_misal = (addr[1:0] != 2'b00);   // word and reserved size
        endcase
    end

    // Reset gates acceptance so a READY-state request can't write during a reset cycle.
    assign w_accept    = !reset && (r_state == ST_READY) && req_valid;
    assign w_commit_st = w_accept && req_we && !w_misal;
    assign w_load      = w_accept && !req_we && !w_misal;

    // Asynchronous array read feeds both the store merge and the load path.
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_merged = w_word;
        case (req_size)
            2'b00:   w_merged[{w_lane, 3'b000} +: 8]    = wdata[7:0];
            2'b01:   w_merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            default: w_merged = wdata;
        endcase
    end

    assign w_byte = w_word[{w_lane, 3'b000} +: 8];
    assign w_half = w_word[{addr[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = w_word;
        case (req_size)
            2'b00:   w_ext = req_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_ext = req_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_ext = w_word;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: clear sweep has priority; it only runs while no request is accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_CLEAR) r_mem[r_clr_cnt] <= '0;
            else if (w_commit_st)    r_mem[w_idx]     <= w_merged;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (w_commit_st) $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, w_merged);
    end
`endif

    // ------------------------------------------------------------------
    // Registered response; rdata holds between loads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_rdata_valid <= w_load;
            r_misalign    <= w_accept && w_misal;
            if (w_load) r_rdata <= w_ext;
        end
    end

    assign rdata_valid = r_rdata_valid;
    assign rdata       = r_rdata;
    assign misalign    = r_misalign;

endmodule

// File: tb/tb_data_memory_be.sv
module tb_data_memory_be;

    localparam int AW    = 4;
    localparam int NWORD = 2 ** AW;
    localparam int NBYTE = NWORD * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        misalign;

    always #5 clk = ~clk;

    data_memory_be #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .rdata_valid  (rdata_valid),
        .rdata        (rdata),
        .misalign     (misalign)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_rdata = 32'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // ---------------- reference model: flat byte array ----------------
    bit [7:0] ref_b [NBYTE];

    function automatic void model_clear();
        for (int i = 0; i < NBYTE; i++) ref_b[i] = 8'd0;
    endfunction

    function automatic int nbytes(input bit [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit is_mis(input bit [1:0] sz, input bit [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic void model_store(input bit [1:0] sz, input bit [31:0] a, input bit [31:0] wd);
        int base = int'(a % NBYTE);
        for (int k = 0; k < nbytes(sz); k++) ref_b[base + k] = 8'(wd >> (8 * k));
    endfunction

    function automatic bit [31:0] model_load(input bit [1:0] sz, input bit uns, input bit [31:0] a);
        int base = int'(a % NBYTE);
        int n    = nbytes(sz);
        bit [31:0] v = 0;
        bit [31:0] lim;
        for (int k = 0; k < n; k++) v = v | (32'(ref_b[base + k]) << (8 * k));
        if (n < 4 && !uns) begin
            lim = 32'd1 << (8 * n);
            if (v >= (lim >> 1)) v = v | ~(lim - 1);
        end
        return v;
    endfunction

    // ---------------- stimulus ----------------
    task automatic apply(input bit vld, input bit we, input bit [1:0] sz, input bit uns,
                         input bit [31:0] a, input bit [31:0] wd);
        req_valid    = vld;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        addr         = a;
        wdata        = wd;
        pc           = 32'h0040_0000 + (a << 2);
        @(negedge clk);
    endtask

    // Counts busy cycles (bounded) and injects requests that must be dropped.
    task automatic sweep(output int cyc, output int bad);
        cyc = 0;
        bad = 0;
        while (busy && cyc < 100) begin
            if (cyc == 10)      apply(1'b1, 1'b1, 2'd2, 1'b0, 32'h14, 32'h5555_5555);
            else if (cyc == 11) apply(1'b1, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
            else if (cyc == 12) apply(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
            else                apply(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
            cyc++;
            if (rdata_valid || misalign) bad++;
        end
        req_valid = 1'b0;
    endtask

    task automatic load_chk(input string nm, input bit [1:0] sz, input bit uns,
                            input bit [31:0] a, input bit [31:0] exp);
        apply(1'b1, 1'b0, sz, uns, a, 32'h0);
        req_valid = 1'b0;
        check({nm, "_vld"}, 32'(rdata_valid), 32'd1);
        check(nm, rdata, exp);
        last_rdata = rdata;
    endtask

    typedef struct {
        string       nm;
        bit          vld;
        bit          we;
        bit [1:0]    sz;
        bit          uns;
        bit [31:0]   a;
        bit [31:0]   wd;
        bit          ev;
        bit [31:0]   er;
        bit          em;
    } vec_t;

    function automatic vec_t mk(input string nm, input bit vld, input bit we, input bit [1:0] sz,
                                input bit uns, input bit [31:0] a, input bit [31:0] wd,
                                input bit ev, input bit [31:0] er, input bit em);
        vec_t v;
        v.nm = nm; v.vld = vld; v.we = we; v.sz = sz; v.uns = uns;
        v.a = a; v.wd = wd; v.ev = ev; v.er = er; v.em = em;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int cyc, bad;
        bit vld, we, uns, ev, em;
        bit [1:0] sz;
        bit [31:0] a, wd, er;

        tbl.push_back(mk("lw_c_clr",    1, 0, 2, 0, 32'h0C, 32'h0,         1, 32'h0000_0000, 0));
        tbl.push_back(mk("sw_8",        1, 1, 2, 0, 32'h08, 32'h1234_5678, 0, 32'h0,         0));
        tbl.push_back(mk("lw_8_raw",    1, 0, 2, 0, 32'h08, 32'h0,         1, 32'h1234_5678, 0));
        tbl.push_back(mk("sb_9",        1, 1, 0, 0, 32'h09, 32'h0000_0080, 0, 32'h0,         0));
        tbl.push_back(mk("lb_9",        1, 0, 0, 0, 32'h09, 32'h0,         1, 32'hFFFF_FF80, 0));
        tbl.push_back(mk("lbu_9",       1, 0, 0, 1, 32'h09, 32'h0,         1, 32'h0000_0080, 0));
        tbl.push_back(mk("lw_8_merge",  1, 0, 2, 0, 32'h08, 32'h0,         1, 32'h1234_8078, 0));
        tbl.push_back(mk("sw_0_clr",    1, 1, 2, 0, 32'h00, 32'h0,         0, 32'h0,         0));
        tbl.push_back(mk("sh_2",        1, 1, 1, 0, 32'h02, 32'h0000_BEEF, 0, 32'h0,         0));
        tbl.push_back(mk("lw_0",        1, 0, 2, 0, 32'h00, 32'h0,         1, 32'hBEEF_0000, 0));
        tbl.push_back(mk("lh_2",        1, 0, 1, 0, 32'h02, 32'h0,         1, 32'hFFFF_BEEF, 0));
        tbl.push_back(mk("lhu_2",       1, 0, 1, 1, 32'h02, 32'h0,         1, 32'h0000_BEEF, 0));
        tbl.push_back(mk("sw_6_mis",    1, 1, 2, 0, 32'h06, 32'hDEAD_BEEF, 0, 32'h0,         1));
        tbl.push_back(mk("idle",        0, 0, 0, 0, 32'h00, 32'h0,         0, 32'h0,         0));
        tbl.push_back(mk("lw_4_unch",   1, 0, 2, 0, 32'h04, 32'h0,         1, 32'h0000_0000, 0));
        tbl.push_back(mk("sh_5_mis",    1, 1, 1, 0, 32'h05, 32'h0000_FFFF, 0, 32'h0,         1));
        tbl.push_back(mk("lw_7_mis",    1, 0, 2, 0, 32'h07, 32'h0,         0, 32'h0,         1));
        tbl.push_back(mk("lb_7",        1, 0, 0, 0, 32'h07, 32'h0,         1, 32'h0000_0000, 0));
        tbl.push_back(mk("sw_wrap",     1, 1, 2, 0, 32'h40, 32'hCAFE_F00D, 0, 32'h0,         0));
        tbl.push_back(mk("lw_0_wrap",   1, 0, 2, 0, 32'h00, 32'h0,         1, 32'hCAFE_F00D, 0));
        tbl.push_back(mk("lw_hi_addr",  1, 0, 2, 0, 32'hFFFF_FF80, 32'h0,  1, 32'hCAFE_F00D, 0));
        tbl.push_back(mk("lrsv_8",      1, 0, 3, 1, 32'h08, 32'h0,         1, 32'h1234_8078, 0));
        tbl.push_back(mk("lrsv_a_mis",  1, 0, 3, 0, 32'h0A, 32'h0,         0, 32'h0,         1));
        tbl.push_back(mk("sb_b",        1, 1, 0, 0, 32'h0B, 32'h0000_007F, 0, 32'h0,         0));
        tbl.push_back(mk("lb_b",        1, 0, 0, 0, 32'h0B, 32'h0,         1, 32'h0000_007F, 0));
        tbl.push_back(mk("lh_a",        1, 0, 1, 0, 32'h0A, 32'h0,         1, 32'h0000_7F34, 0));
        tbl.push_back(mk("lh_8",        1, 0, 1, 0, 32'h08, 32'h0,         1, 32'hFFFF_8078, 0));
        tbl.push_back(mk("lhu_8",       1, 0, 1, 1, 32'h08, 32'h0,         1, 32'h0000_8078, 0));
        tbl.push_back(mk("lb_0",        1, 0, 0, 0, 32'h00, 32'h0,         1, 32'h0000_000D, 0));
        tbl.push_back(mk("lb_1",        1, 0, 0, 0, 32'h01, 32'h0,         1, 32'hFFFF_FFF0, 0));
        tbl.push_back(mk("sh_0",        1, 1, 1, 0, 32'h00, 32'hAB12_1234, 0, 32'h0,         0));
        tbl.push_back(mk("lw_0_sh",     1, 0, 2, 0, 32'h00, 32'h0,         1, 32'hCAFE_1234, 0));

        // ---------------- reset and initial sweep ----------------
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; addr = 32'd0; wdata = 32'd0; pc = 32'd0;
        @(negedge clk);
        check("rst_busy",     32'(busy),        32'd1);
        check("rst_rvalid",   32'(rdata_valid), 32'd0);
        check("rst_rdata",    rdata,            32'd0);
        check("rst_misalign", 32'(misalign),    32'd0);
        reset = 1'b0;
        sweep(cyc, bad);
        check("sweep_len",     32'(cyc), 32'd16);
        check("sweep_dropped", 32'(bad), 32'd0);
        model_clear();
        last_rdata = 32'd0;

        // ---------------- directed table ----------------
        foreach (tbl[i]) begin
            apply(tbl[i].vld, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd);
            if (tbl[i].vld && tbl[i].we && !is_mis(tbl[i].sz, tbl[i].a))
                model_store(tbl[i].sz, tbl[i].a, tbl[i].wd);
            check({tbl[i].nm, "_vld"}, 32'(rdata_valid), 32'(tbl[i].ev));
            check({tbl[i].nm, "_mis"}, 32'(misalign),    32'(tbl[i].em));
            if (tbl[i].ev) last_rdata = tbl[i].er;
            check({tbl[i].nm, "_rdata"}, rdata, last_rdata);
        end

        // ---------------- randomized against the model ----------------
        for (int n = 0; n < 400; n++) begin
            vld = ($urandom_range(0, 9) != 0);
            we  = ($urandom_range(0, 2) == 0);
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd  = $urandom;
            em  = vld && is_mis(sz, a);
            ev  = vld && !we && !is_mis(sz, a);
            er  = ev ? model_load(sz, uns, a) : last_rdata;
            apply(vld, we, sz, uns, a, wd);
            if (vld && we && !is_mis(sz, a)) model_store(sz, a, wd);
            check("rnd_vld",   32'(rdata_valid), 32'(ev));
            check("rnd_mis",   32'(misalign),    32'(em));
            check("rnd_rdata", rdata,            er);
            last_rdata = er;
        end
        req_valid = 1'b0;
        @(negedge clk);

        // ---------------- reset in the middle of the sweep ----------------
        apply(1'b1, 1'b1, 2'd2, 1'b0, 32'h0C, 32'hAAAA_AAAA);
        load_chk("pre_rst_w3", 2'd2, 1'b0, 32'h0C, 32'hAAAA_AAAA);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy0", 32'(busy), 32'd1);
        for (int k = 0; k < 7; k++) @(negedge clk);
        check("mid_busy7", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("restart_rdata", rdata, 32'd0);
        sweep(cyc, bad);
        check("restart_len",     32'(cyc), 32'd16);
        check("restart_dropped", 32'(bad), 32'd0);
        load_chk("post_w3", 2'd2, 1'b0, 32'h0C, 32'h0000_0000);
        load_chk("post_w5", 2'd2, 1'b0, 32'h14, 32'h0000_0000);
        load_chk("post_w2", 2'd2, 1'b0, 32'h08, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
